// File: rtl/alu_pkg.sv
// Shared ALU definitions: default width, op codes (common with aluctrl), FSM and shift-kind encodings.
package alu_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_e;

  typedef enum logic [1:0] {
    SH_LEFT        = 2'd0,
    SH_RIGHT_LOG   = 2'd1,
    SH_RIGHT_ARITH = 2'd2
  } shift_kind_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  function automatic shift_kind_e shift_kind(input logic [3:0] op);
    case (op)
      ALU_SRL: return SH_RIGHT_LOG;
      ALU_SRA: return SH_RIGHT_ARITH;
      default: return SH_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Serial 1-bit/cycle shifter: loads the source and amount, steps one position per cycle on request.
// last_o flags the final step so the caller can decide whether to take it or hold.
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            clear_i,
  input  shift_kind_e     kind_i,
  input  logic [XLEN-1:0] src_i,
  input  logic [SHW-1:0]  shamt_i,
  output logic [XLEN-1:0] step_val_o,
  output logic            last_o
);

  logic [XLEN-1:0] acc_q, acc_d;
  logic [SHW-1:0]  count_q, count_d;
  shift_kind_e     kind_q, kind_d;

  always_comb begin
    case (kind_q)
      SH_LEFT:      step_val_o = {acc_q[XLEN-2:0], 1'b0};
      SH_RIGHT_LOG: step_val_o = {1'b0, acc_q[XLEN-1:1]};
      default:      step_val_o = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
    endcase
  end

  assign last_o = (count_q == SHW'(1));

  // NOTE: every output of this block is given a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    kind_d  = kind_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      acc_d   = src_i;
      count_d = shamt_i;
      kind_d  = kind_i;
    end else if (step_i) begin
      acc_d   = step_val_o;
      count_d = count_q - SHW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; the accumulator is reset too so reset leaves no stale shift.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_q   <= '0;
      count_q <= '0;
      kind_q  <= SH_LEFT;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
      kind_q  <= kind_d;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready on both sides and a one-entry registered result slot.
// Define ALU_EXEC_BARREL_SHIFT_EN for single-cycle barrel shifts; default is the serial shifter.
module alu_exec
  import alu_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [3:0]      aluctrl_ctrl_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);

  logic            slot_free;
  logic            accept;
  logic            wr_en;
  logic [XLEN-1:0] wr_data;
  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  shamt;

  logic            valid_q, valid_d;
  logic            zero_q, zero_d;
  logic [XLEN-1:0] result_q, result_d;

  assign shamt     = op_b_i[SHW-1:0];
  assign slot_free = !valid_q || ready_i;
  assign accept    = valid_i && ready_o;

  // Single-cycle datapath; in the serial build shift codes only reach here with shamt == 0.
  always_comb begin
    alu_res = '0;
    case (aluctrl_ctrl_i)
      ALU_ADD:  alu_res = op_a_i + op_b_i;
      ALU_SUB:  alu_res = op_a_i - op_b_i;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a_i < op_b_i)};
      ALU_XOR:  alu_res = op_a_i ^ op_b_i;
      ALU_OR:   alu_res = op_a_i | op_b_i;
      ALU_AND:  alu_res = op_a_i & op_b_i;
`ifdef ALU_EXEC_BARREL_SHIFT_EN
      ALU_SLL:  alu_res = op_a_i << shamt;
      ALU_SRL:  alu_res = op_a_i >> shamt;
      ALU_SRA:  alu_res = XLEN'($signed(op_a_i) >>> shamt);
`else
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a_i;
`endif
      default:  alu_res = '0;
    endcase
  end

`ifdef ALU_EXEC_BARREL_SHIFT_EN

  assign ready_o = slot_free && !flush_i;

  always_comb begin
    wr_en   = accept;
    wr_data = alu_res;
  end

`else

  alu_state_e      state_q, state_d;
  logic            sh_load;
  logic            sh_step;
  logic            sh_last;
  logic [XLEN-1:0] sh_val;

  assign ready_o = (state_q == ST_IDLE) && slot_free && !flush_i;

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_data = alu_res;
    sh_load = 1'b0;
    sh_step = 1'b0;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_shift(aluctrl_ctrl_i) && (shamt != '0)) begin
              sh_load = 1'b1;
              state_d = ST_SHIFT;
            end else begin
              wr_en = 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          // The final step is taken only when the slot can accept it; otherwise hold at count 1.
          if (!sh_last) begin
            sh_step = 1'b1;
          end else if (slot_free) begin
            sh_step = 1'b1;
            wr_en   = 1'b1;
            wr_data = sh_val;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  alu_shift_unit #(.XLEN(XLEN)) u_shift (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .load_i     (sh_load),
    .step_i     (sh_step),
    .clear_i    (flush_i),
    .kind_i     (shift_kind(aluctrl_ctrl_i)),
    .src_i      (op_a_i),
    .shamt_i    (shamt),
    .step_val_o (sh_val),
    .last_o     (sh_last)
  );

`endif

  // Output slot: a write wins over a drain, so back-to-back ops keep valid_o high.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    zero_d   = zero_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (wr_en) begin
      valid_d  = 1'b1;
      result_d = wr_data;
      zero_d   = (wr_data == '0);
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;

endmodule
